// File: rtl/execute_stage_pkg.sv
//==============================================================================
// execute_stage_pkg : ALU-class encodings, funct3 codes, ALU function enum
// Revision 1.0 - initial release
//==============================================================================
`default_nettype none

package execute_stage_pkg;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL, FN_SRA, FN_SLT
  } alu_fn_e;

  // funct7[5] only selects sub for R-type 000; the immediate form is always addi.
  function automatic alu_fn_e decode_alu_fn(input logic [1:0] op,
                                            input logic [2:0] f3,
                                            input logic       f7b5);
    alu_fn_e fn;
    fn = FN_ADD;
    case (op)
      ALU_OP_ADD: fn = FN_ADD;
      ALU_OP_SUB: fn = FN_SUB;
      default: begin
        case (f3)
          F3_ADD_SUB: fn = (op == ALU_OP_R && f7b5) ? FN_SUB : FN_ADD;
          F3_SLL:     fn = FN_SLL;
          F3_SLT:     fn = FN_SLT;
          F3_XOR:     fn = FN_XOR;
          F3_SR:      fn = f7b5 ? FN_SRA : FN_SRL;
          F3_OR:      fn = FN_OR;
          F3_AND:     fn = FN_AND;
          default:    fn = FN_ADD;
        endcase
      end
    endcase
    return fn;
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_stage_alu.sv
//==============================================================================
// alu : combinational execute ALU with zero detect
// Revision 1.0 - initial release
//==============================================================================
`default_nettype none

module alu
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_b5,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  alu_fn_e    fn;
  logic [5:0] shamt;

  assign fn    = decode_alu_fn(alu_op, funct3, funct7_b5);
  assign shamt = b[5:0];

  always_comb begin
    result = '0;
    case (fn)
      FN_ADD:  result = a + b;
      FN_SUB:  result = a - b;
      FN_AND:  result = a & b;
      FN_OR:   result = a | b;
      FN_XOR:  result = a ^ b;
      FN_SLL:  result = a << shamt;
      FN_SRL:  result = a >> shamt;
      FN_SRA:  result = $signed(a) >>> shamt;
      FN_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
//==============================================================================
// execute_stage : EX stage with operand muxing, ALU, branch resolve, EX/MEM reg
// Optional macro FORWARDING_EN adds EX/MEM and MEM/WB operand forwarding.
// Revision 1.0 - initial release
//==============================================================================
`default_nettype none

module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [31:0]       instruction,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic              MemtoReg,
  input  logic              regwrite,
  input  logic              branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              alu_src,
  input  logic [1:0]        alu_op,
  input  logic              stall,
  input  logic              flush,
  input  logic [4:0]        mem_wb_rd,
  input  logic              mem_wb_regwrite,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [4:0]        rd_out,
  output logic              MemtoReg_out,
  output logic              regwrite_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              valid_out,
  output logic              zero_flag,
  output logic              branch_taken,
  output logic [PC_W-1:0]   branch_target
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic [PC_W-1:0]   target;
  logic              unused_bits;

`ifdef FORWARDING_EN
  // A load in EX/MEM has no data yet, so it must not be forwarded from there.
  logic ex_fwd_ok;
  assign ex_fwd_ok = regwrite_out & valid_out & ~MemRead_out;

  assign op_a  = (ex_fwd_ok && rd_out == rs1 && rs1 != 5'd0)          ? alu_result_out :
                 (mem_wb_regwrite && mem_wb_rd == rs1 && rs1 != 5'd0) ? mem_wb_data    :
                                                                        rs1_data;
  assign fwd_b = (ex_fwd_ok && rd_out == rs2 && rs2 != 5'd0)          ? alu_result_out :
                 (mem_wb_regwrite && mem_wb_rd == rs2 && rs2 != 5'd0) ? mem_wb_data    :
                                                                        rs2_data;
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:0]};
`else
  assign op_a  = rs1_data;
  assign fwd_b = rs2_data;
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:0],
                         rs1, rs2, mem_wb_rd, mem_wb_regwrite, mem_wb_data};
`endif

  assign op_b   = alu_src ? imm : fwd_b;
  assign target = pc_in + imm[PC_W-1:0];

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .alu_op    (alu_op),
    .funct3    (instruction[14:12]),
    .funct7_b5 (instruction[30]),
    .a         (op_a),
    .b         (op_b),
    .result    (alu_res),
    .zero      (alu_zero)
  );

  // Reset beats flush, flush beats stall.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      MemtoReg_out   <= 1'b0;
      regwrite_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      MemWrite_out   <= 1'b0;
      valid_out      <= 1'b0;
      zero_flag      <= 1'b0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
    end else if (!stall) begin
      alu_result_out <= alu_res;
      store_data_out <= fwd_b;
      rd_out         <= rd;
      MemtoReg_out   <= MemtoReg;
      regwrite_out   <= regwrite;
      MemRead_out    <= MemRead;
      MemWrite_out   <= MemWrite;
      valid_out      <= 1'b1;
      zero_flag      <= alu_zero;
      branch_taken   <= branch & alu_zero;
      branch_target  <= target;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
//==============================================================================
// tb_execute_stage : directed scoreboard bench for execute_stage
// Revision 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_execute_stage;

  typedef struct packed {
    logic [63:0] res;
    logic [63:0] st;
    logic [4:0]  rdo;
    logic        m2r;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        vld;
    logic        zf;
    logic        tk;
    logic [7:0]  tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc_in;
  logic [63:0] rs1_data, rs2_data, imm;
  logic [31:0] instruction;
  logic [4:0]  rs1, rs2, rd;
  logic        MemtoReg, regwrite, branch, MemRead, MemWrite, alu_src;
  logic [1:0]  alu_op;
  logic        stall, flush;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite;
  logic [63:0] mem_wb_data;
  logic [63:0] alu_result_out, store_data_out;
  logic [4:0]  rd_out;
  logic        MemtoReg_out, regwrite_out, MemRead_out, MemWrite_out, valid_out;
  logic        zero_flag, branch_taken;
  logic [7:0]  branch_target;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t last;

  always #5 clk = ~clk;

  execute_stage #(.DATA_W(64), .PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .instruction(instruction), .rs1(rs1), .rs2(rs2), .rd(rd),
    .MemtoReg(MemtoReg), .regwrite(regwrite), .branch(branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .alu_src(alu_src),
    .alu_op(alu_op), .stall(stall), .flush(flush),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_data(mem_wb_data),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .rd_out(rd_out), .MemtoReg_out(MemtoReg_out), .regwrite_out(regwrite_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .valid_out(valid_out), .zero_flag(zero_flag),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  // Reference ALU written straight from the operation table.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f7, input logic [63:0] a,
                                        input logic [63:0] b);
    int sh;
    sh = int'(b[5:0]);
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (f3 == 3'b000) return (op == 2'b10 && f7) ? a - b : a + b;
    if (f3 == 3'b111) return a & b;
    if (f3 == 3'b110) return a | b;
    if (f3 == 3'b100) return a ^ b;
    if (f3 == 3'b001) return a << sh;
    if (f3 == 3'b101) return f7 ? 64'($signed(a) >>> sh) : a >> sh;
    if (f3 == 3'b010) return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
    return a + b;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic f7);
    return {1'b0, f7, 15'd0, f3, 12'd0};
  endfunction

  // Expected EX/MEM contents for a normally captured instruction.
  function automatic exp_t normal(input logic [63:0] res, input logic [63:0] st);
    exp_t e;
    e.res = res;       e.st = st;          e.rdo = rd;
    e.m2r = MemtoReg;  e.rw = regwrite;    e.mr = MemRead;
    e.mw  = MemWrite;  e.vld = 1'b1;       e.zf = (res == 64'd0);
    e.tk  = branch & (res == 64'd0);
    e.tgt = pc_in + imm[7:0];
    return e;
  endfunction

  task automatic defaults();
    rst_n = 1'b1; pc_in = 8'd0; rs1_data = '0; rs2_data = '0; imm = '0;
    instruction = '0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd1;
    MemtoReg = 1'b0; regwrite = 1'b0; branch = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; alu_src = 1'b0; alu_op = 2'b00; stall = 1'b0; flush = 1'b0;
    mem_wb_rd = 5'd0; mem_wb_regwrite = 1'b0; mem_wb_data = '0;
  endtask

  // Push the expectation, clock once, then compare 1 time unit after the edge.
  task automatic step(input exp_t e, input string tag);
    exp_t exp_v, obs;
    sb.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    obs = '{alu_result_out, store_data_out, rd_out, MemtoReg_out, regwrite_out,
            MemRead_out, MemWrite_out, valid_out, zero_flag, branch_taken,
            branch_target};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [2:0]  f3s [9];
    logic        f7s [9];
    logic [63:0] as  [9];
    logic [63:0] bs  [9];

    f3s = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b101, 3'b010, 3'b010};
    f7s = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
    as  = '{64'd10, 64'hF0F0, 64'hF000, 64'hFF00, 64'd3, 64'h8000_0000_0000_0000,
            64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    bs  = '{64'd3, 64'h0FF0, 64'h000F, 64'h0FF0, 64'd65, 64'd4, 64'd4, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFF};

    defaults();
    @(negedge clk);

    rst_n = 1'b0; regwrite = 1'b1; rs1_data = 64'd9;
    step('0, "reset");
    defaults();

    alu_op = 2'b10; instruction = mk_instr(3'b000, 1'b0);
    rs1_data = 64'd7; rs2_data = -64'sd3; rd = 5'd3; regwrite = 1'b1;
    step(normal(64'd4, -64'sd3), "rtype_add");

    defaults();
    alu_op = 2'b01; rs1_data = 64'd5; rs2_data = 64'd5; branch = 1'b1;
    pc_in = 8'd250; imm = 64'd12;
    begin
      exp_t e;
      e = normal(64'd0, 64'd5);
      e.zf = 1'b1; e.tk = 1'b1; e.tgt = 8'd6;
      step(e, "beq_taken");
    end

    defaults();
    alu_op = 2'b10; regwrite = 1'b1;
    for (int i = 0; i < 9; i++) begin
      instruction = mk_instr(f3s[i], f7s[i]);
      rs1_data = as[i]; rs2_data = bs[i]; rd = 5'(i + 2);
      step(normal(model(2'b10, f3s[i], f7s[i], as[i], bs[i]), bs[i]),
           $sformatf("rtype_%0d", i));
    end

    // addi with funct7[5]=1 still adds; store data is rs2 not imm.
    defaults();
    alu_op = 2'b11; alu_src = 1'b1; instruction = mk_instr(3'b000, 1'b1);
    rs1_data = 64'd100; imm = 64'd20; rs2_data = 64'hABCD; MemWrite = 1'b1;
    step(normal(64'd120, 64'hABCD), "addi_f7_ignored");

    alu_op = 2'b11; instruction = mk_instr(3'b101, 1'b1);
    rs1_data = 64'hFFFF_FFFF_FFFF_FF00; imm = 64'd4;
    step(normal(64'hFFFF_FFFF_FFFF_FFF0, 64'hABCD), "srai");

    defaults();
    rs1_data = 64'hFFFF_FFFF_FFFF_FFFF; rs2_data = 64'd1; branch = 1'b0;
    step(normal(64'd0, 64'd1), "add_wrap_no_branch");

    // Load a reference value, then stall three cycles with changing inputs.
    defaults();
    rs1_data = 64'd40; rs2_data = 64'd2; rd = 5'd9; regwrite = 1'b1; MemtoReg = 1'b1;
    pc_in = 8'd16; imm = 64'd4;
    step(normal(64'd42, 64'd2), "pre_stall");
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; rs1_data = 64'(i * 11 + 1); rd = 5'(20 + i); MemWrite = 1'b1;
      step(last, $sformatf("stall_%0d", i));
    end
    flush = 1'b1;
    step('0, "stall_flush_bubble");

    defaults();
    rs1_data = 64'd8; rd = 5'd4; regwrite = 1'b1;
    step(normal(64'd8, 64'd0), "post_flush_load");
    stall = 1'b1; rst_n = 1'b0;
    step('0, "reset_mid_stall");
    defaults();
    rs1_data = 64'd6; rs2_data = 64'd6; alu_op = 2'b01; rd = 5'd12;
    step(normal(64'd0, 64'd6), "first_after_reset");

    // Forwarding sequence: behaviour depends on the build.
    defaults();
    rd = 5'd5; regwrite = 1'b1; rs1_data = 64'd4; rs2_data = 64'd6;
    step(normal(64'd10, 64'd6), "fwd_producer");
    defaults();
    alu_op = 2'b01; rs1 = 5'd5; rs1_data = 64'd0; rs2_data = 64'd3; rd = 5'd7;
`ifdef FORWARDING_EN
    step(normal(64'd7, 64'd3), "fwd_ex_mem");
`else
    step(normal(-64'sd3, 64'd3), "no_fwd_ex_mem");
`endif

    defaults();
    rd = 5'd0; regwrite = 1'b1; rs1_data = 64'd10;
    step(normal(64'd10, 64'd0), "x0_producer");
    defaults();
    alu_op = 2'b01; rs1 = 5'd0; rs1_data = 64'd0; rs2_data = 64'd3;
    step(normal(-64'sd3, 64'd3), "x0_not_forwarded");

    defaults();
    rd = 5'd6; regwrite = 1'b1; rs1_data = 64'd1;
    step(normal(64'd1, 64'd0), "ex_mem_val_1");
    mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd6; mem_wb_data = 64'd2;
    rs1 = 5'd6; rs1_data = 64'd100; rd = 5'd8;
`ifdef FORWARDING_EN
    step(normal(64'd1, 64'd0), "ex_mem_priority");
`else
    step(normal(64'd100, 64'd0), "no_fwd_priority");
`endif
    rs2 = 5'd6; rs2_data = 64'd50; alu_src = 1'b1; imm = 64'd0;
`ifdef FORWARDING_EN
    step(normal(64'd2, 64'd2), "mem_wb_fwd");
`else
    step(normal(64'd100, 64'd50), "no_fwd_mem_wb");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
